// File: rtl/mayo_seed_loader.sv
// Seed loader for the MAYO keygen: assembles SEED_WORDS 32-bit words, then hands
// the frozen seed to the keygen FSM with a registered start pulse and waits for done.
module mayo_seed_loader #(
  parameter int SEED_WORDS = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    wr_valid,
  input  logic [31:0]             wr_data,
  output logic                    wr_ready,
  input  logic                    start_req,
  input  logic                    clear,
  output logic [32*SEED_WORDS-1:0] seed_out,
  output logic                    kg_start,
  input  logic                    kg_done,
  output logic [3:0]              word_cnt,
  output logic [1:0]              state_o,
  output logic                    err
);

  // Handshake: a word transfers on a rising edge where wr_valid && wr_ready;
  // wr_data must be stable while wr_valid is high, and wr_ready never depends on wr_valid.

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(SEED_WORDS - 1);

  state_t                    state_q, state_d;
  logic [32*SEED_WORDS-1:0]  seed_q, seed_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      kg_start_q, kg_start_d;
  logic                      ready_c;
  logic                      accept_c;
  int unsigned               wr_idx;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= ST_LOAD;
      seed_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      kg_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      kg_start_q <= kg_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    kg_start_d = 1'b0;
    wr_idx     = 32'(cnt_q);
    ready_c    = ((state_q == ST_LOAD) || (state_q == ST_DONE)) && !clear;
    accept_c   = wr_valid && ready_c;

    if (clear && (state_q != ST_WAIT)) begin
      state_d = ST_LOAD;
      seed_d  = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      // Only WAIT reaches here with clear high: the running seed stays protected.
      if (clear) err_d = 1'b1;
      if (start_req && (state_q != ST_ARMED)) err_d = 1'b1;
      if (kg_done && (state_q != ST_WAIT)) err_d = 1'b1;

      case (state_q)
        ST_LOAD: begin
          if (accept_c) begin
            seed_d[32*wr_idx +: 32] = wr_data;
            cnt_d                   = cnt_q + 4'd1;
            if (cnt_q == LAST_IDX) state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (start_req) begin
            kg_start_d = 1'b1;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (kg_done) state_d = ST_DONE;
        end
        ST_DONE: begin
          // A write here begins a fresh seed; a one-word seed is complete at once.
          if (accept_c) begin
            seed_d        = '0;
            seed_d[31:0]  = wr_data;
            cnt_d         = 4'd1;
            state_d       = (SEED_WORDS == 1) ? ST_ARMED : ST_LOAD;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  assign wr_ready = ready_c;
  assign seed_out = seed_q;
  assign kg_start = kg_start_q;
  assign word_cnt = cnt_q;
  assign state_o  = state_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mayo_seed_loader.sv
// Directed bench for mayo_seed_loader: expected seed words go into a queue as they
// are driven and are popped against seed_out whenever the seed is meant to be observed.
module tb_mayo_seed_loader;

  localparam int SW = 8;

  logic            ACLK;
  logic            ARESET;
  logic            wr_valid;
  logic [31:0]     wr_data;
  logic            wr_ready;
  logic            start_req;
  logic            clear;
  logic [32*SW-1:0] seed_out;
  logic            kg_start;
  logic            kg_done;
  logic [3:0]      word_cnt;
  logic [1:0]      state_o;
  logic            err;

  logic [31:0] exp_q[$];
  int n_cmp;
  int n_mis;

  mayo_seed_loader #(.SEED_WORDS(SW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .start_req (start_req),
    .clear     (clear),
    .seed_out  (seed_out),
    .kg_start  (kg_start),
    .kg_done   (kg_done),
    .word_cnt  (word_cnt),
    .state_o   (state_o),
    .err       (err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_seed(input string tag);
    for (int i = 0; i < SW; i++) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $error("FAIL %s[%0d]: observed %h expected <queue empty>", tag, i, seed_out[32*i +: 32]);
      end else begin
        chk($sformatf("%s[%0d]", tag, i), seed_out[32*i +: 32], exp_q.pop_front());
      end
    end
  endtask

  task automatic push_count_seed();
    for (int i = 1; i <= SW; i++) exp_q.push_back(32'(i));
  endtask

  task automatic push_zero_seed();
    for (int i = 0; i < SW; i++) exp_q.push_back(32'h0);
  endtask

  task automatic write_word(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_data  = $urandom;
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_done();
    kg_done = 1'b1;
    tick();
    kg_done = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    ARESET    = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    start_req = 1'b0;
    clear     = 1'b0;
    kg_done   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_kg_start", 32'(kg_start), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    push_zero_seed();
    check_seed("rst_seed");
    ARESET = 1'b0;
    tick();
    chk("rst_ready", 32'(wr_ready), 32'd1);

    // Back-to-back load of 1..8
    for (int i = 1; i <= SW; i++) write_word(32'(i));
    push_count_seed();
    chk("b2b_cnt", 32'(word_cnt), 32'd8);
    chk("b2b_state", 32'(state_o), 32'd1);
    chk("b2b_ready", 32'(wr_ready), 32'd0);
    check_seed("b2b_seed");

    // A word offered in ARMED must be ignored
    write_word(32'hFFFF_FFFF);
    chk("armed_wr_cnt", 32'(word_cnt), 32'd8);
    chk("armed_wr_state", 32'(state_o), 32'd1);
    chk("armed_wr_err", 32'(err), 32'd0);

    // start_req -> registered kg_start pulse
    start_req = 1'b1;
    #1;
    chk("kg_start_no_comb", 32'(kg_start), 32'd0);
    tick();
    start_req = 1'b0;
    chk("kg_start_hi", 32'(kg_start), 32'd1);
    chk("start_state", 32'(state_o), 32'd2);
    tick();
    chk("kg_start_lo", 32'(kg_start), 32'd0);
    chk("wait_state", 32'(state_o), 32'd2);

    // clear in WAIT is refused but flagged
    pulse_clear();
    chk("wait_clr_state", 32'(state_o), 32'd2);
    chk("wait_clr_err", 32'(err), 32'd1);
    chk("wait_clr_cnt", 32'(word_cnt), 32'd8);
    push_count_seed();
    check_seed("wait_clr_seed");

    pulse_done();
    chk("done_state", 32'(state_o), 32'd3);
    chk("done_cnt", 32'(word_cnt), 32'd8);
    chk("done_ready", 32'(wr_ready), 32'd1);
    push_count_seed();
    check_seed("done_seed");

    // Write in DONE starts a fresh seed
    write_word(32'hDEAD_BEEF);
    chk("renew_state", 32'(state_o), 32'd0);
    chk("renew_cnt", 32'(word_cnt), 32'd1);
    chk("renew_err_sticky", 32'(err), 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    for (int i = 1; i < SW; i++) exp_q.push_back(32'h0);
    check_seed("renew_seed");

    // clear in LOAD drops err, then start_req at word_cnt=3
    pulse_clear();
    chk("load_clr_err", 32'(err), 32'd0);
    chk("load_clr_cnt", 32'(word_cnt), 32'd0);
    write_word(32'hA);
    write_word(32'hB);
    write_word(32'hC);
    pulse_start();
    chk("early_start_kg", 32'(kg_start), 32'd0);
    chk("early_start_err", 32'(err), 32'd1);
    chk("early_start_cnt", 32'(word_cnt), 32'd3);
    chk("early_start_state", 32'(state_o), 32'd0);

    // clear wins over a simultaneous write
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h1234_5678;
    #1;
    chk("clr_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk("clr_wr_cnt", 32'(word_cnt), 32'd0);
    chk("clr_wr_state", 32'(state_o), 32'd0);
    chk("clr_wr_err", 32'(err), 32'd0);
    push_zero_seed();
    check_seed("clr_wr_seed");

    // Load with random gaps: must match the back-to-back seed
    for (int i = 1; i <= SW; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      write_word(32'(i));
    end
    push_count_seed();
    chk("gap_cnt", 32'(word_cnt), 32'd8);
    chk("gap_state", 32'(state_o), 32'd1);
    check_seed("gap_seed");

    // kg_done in ARMED flags err; clear in ARMED wipes everything
    pulse_done();
    chk("armed_done_err", 32'(err), 32'd1);
    chk("armed_done_state", 32'(state_o), 32'd1);
    pulse_clear();
    chk("armed_clr_state", 32'(state_o), 32'd0);
    chk("armed_clr_cnt", 32'(word_cnt), 32'd0);
    chk("armed_clr_err", 32'(err), 32'd0);
    push_zero_seed();
    check_seed("armed_clr_seed");

    // Asynchronous reset in the middle of LOAD
    for (int i = 0; i < 5; i++) write_word($urandom);
    chk("mid_cnt", 32'(word_cnt), 32'd5);
    pulse_start();
    chk("mid_err", 32'(err), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("async_cnt", 32'(word_cnt), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_kg_start", 32'(kg_start), 32'd0);
    push_zero_seed();
    check_seed("async_seed");
    tick();
    ARESET = 1'b0;
    tick();

    // Reset during WAIT abandons the handshake; late kg_done is an error
    for (int i = 1; i <= SW; i++) write_word(32'(i));
    pulse_start();
    tick();
    chk("pre_rst_wait", 32'(state_o), 32'd2);
    ARESET = 1'b1;
    #1;
    chk("wait_rst_state", 32'(state_o), 32'd0);
    tick();
    ARESET = 1'b0;
    tick();
    pulse_done();
    chk("late_done_err", 32'(err), 32'd1);
    chk("late_done_state", 32'(state_o), 32'd0);
    chk("late_done_cnt", 32'(word_cnt), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
